rv32_trap_ctrl: RTL and testbench
=================================

// Module: rv32_trap_ctrl
// PURPOSE
//  Owns the machine-mode trap CSRs (mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval)
//  and sequences trap entry and MRET. Sits beside the counter/ID CSR file. Takes exceptions
//  from the pipeline and level IRQs, stalls the pipeline, updates trap state, then flushes and
//  redirects fetch. Services CSR-instruction reads and writes to its own addresses.
// PARAMETERS
//  MTVEC_RESET  32'h0000_0000  reset value of mtvec (BASE and MODE)
// PORTS
//  clk                  in   1   clock; all state updates on posedge
//  reset                in   1   synchronous, active-high reset
//  exc_valid_in         in   1   synchronous exception from retiring instruction
//  exc_cause_in         in   4   exception code (mcause[3:0]; mcause[31]=0)
//  exc_pc_in            in   32  PC of the faulting instruction
//  exc_tval_in          in   32  value for mtval
//  mret_in              in   1   MRET is retiring
//  boundary_in          in   1   instruction boundary; interrupt may be taken; next PC valid
//  next_pc_in           in   32  PC to save in mepc on interrupt
//  irq_timer_in         in   1   machine timer IRQ, level
//  irq_ext_in           in   1   machine external IRQ, level
//  csr_read_in          in   1   CSR instruction reads csr_in
//  csr_write_in         in   1   CSR instruction writes csr_write_value_in to csr_in
//  csr_in               in   12  CSR address
//  csr_write_value_in   in   32  final RW/RS/RC value, already computed by the pipeline
//  csr_read_value_out   out  32  read data, combinational; 0 when csr_hit_out=0
//  csr_hit_out          out  1   csr_in is owned by this block
//  busy_out             out  1   pipeline must stall
//  redirect_valid_out   out  1   one-cycle pulse: flush pipeline, fetch from redirect_pc_out
//  redirect_pc_out      out  32  fetch target while redirect_valid_out=1
// BEHAVIOUR
//  Reset: FSM=IDLE; outputs busy/redirect_valid=0 and redirect_pc=0; mstatus.MIE=MPIE=0;
//   mie, mscratch, mepc, mcause, mtval = 0; mtvec=MTVEC_RESET.
//  mstatus.MPP always reads 2'b11. Other unimplemented bits read 0.
//  mip is read-only: MTIP=irq_timer_in (bit 7), MEIP=irq_ext_in (bit 11). Writes to mip are ignored.
//  mie: only bits 7 and 11 are writable. mepc[1:0] is hardwired 0.
//  FSM states: IDLE, TRAP, RETURN, REDIRECT. busy_out=1 in every state other than IDLE (registered).
//  IDLE, evaluated each cycle in this priority order:
//   1 exc_valid_in -> TRAP; latch cause/pc/tval.
//   2 pending IRQ (MIE & boundary_in & (mie&mip)!=0) -> TRAP; mepc=next_pc_in; ext(11) beats timer(7).
//   3 mret_in -> RETURN.
//  TRAP (1 cycle): mepc, mcause, mtval written; MPIE<=MIE, MIE<=0; go to REDIRECT with
//   target = mtvec BASE. For interrupts, mcause[31]=1 and mtval=0.
//  RETURN (1 cycle): MIE<=MPIE, MPIE<=1; go to REDIRECT with target=mepc.
//  REDIRECT (1 cycle): redirect_valid_out=1, redirect_pc_out=target; then IDLE.
//  Latency: event sampled at edge N; redirect_valid_out high during cycle N+2.
//  CSR write commits at posedge only in IDLE with no event accepted that cycle. A write that
//   coincides with an accepted exception/IRQ/MRET is dropped.
//  CSR reads are combinational and valid in every state.
//  IRQ deasserting after acceptance: the trap still completes.
//  Reset in any state: returns to IDLE next cycle and drops the in-flight redirect.
// CONFIGURATION
//  RV32_TRAP_VECTORED_EN defined:
//   mtvec.MODE is writable (0=direct, 1=vectored; 2,3 write as 0).
//   Interrupt target = BASE + 4*code when MODE=1. Exceptions always go to BASE.
//  RV32_TRAP_VECTORED_EN undefined: mtvec[1:0] hardwired 0; all traps go to BASE.
// STRUCTURE
//  CSR address `defines (RV32_CSR_MSTATUS 300, MIE 304, MTVEC 305, MSCRATCH 340, MEPC 341,
//   MCAUSE 342, MTVAL 343, MIP 344) and interrupt cause codes go in the shared CSR define set.
//   The FSM state enum is local.
//  Sub-module rv32_trap_irq_sel: combinational pending-IRQ priority select -> valid + code.
// TESTING
//  1 reset; exc_valid_in, cause=2, pc=0x100, mtvec=0x80 -> redirect_pc_out=0x80 at N+2;
//    mepc=0x100, mcause=2, MIE=0.
//  2 MIE=1, mie=0x880, irq_timer_in=1 and irq_ext_in=1, boundary_in=1 -> mcause=0x8000000B,
//    MPIE=1, MIE=0.
//  3 after test 2, mret_in -> redirect_pc_out=mepc, MIE=1, MPIE=1; busy_out low after redirect.
//  4 exc_valid_in and csr_write_in to mscratch=0x55 in the same cycle -> mscratch unchanged,
//    trap is taken.
//  5 VECTORED_EN: mtvec=0x201, timer IRQ -> target 0x21C.
//    Without VECTORED_EN: mtvec reads 0x200 -> target 0x200.
//  6 reset asserted in TRAP -> no redirect pulse; all CSRs at reset values.

Source files
------------

// File: rtl/rv32_trap_ctrl_pkg.sv
// Shared CSR address defines, interrupt cause codes and mtvec legalisation for the trap controller.
// Optional feature macro: RV32_TRAP_VECTORED_EN (vectored mtvec mode).
`ifndef RV32_CSR_MSTATUS
`define RV32_CSR_MSTATUS  12'h300
`define RV32_CSR_MIE      12'h304
`define RV32_CSR_MTVEC    12'h305
`define RV32_CSR_MSCRATCH 12'h340
`define RV32_CSR_MEPC     12'h341
`define RV32_CSR_MCAUSE   12'h342
`define RV32_CSR_MTVAL    12'h343
`define RV32_CSR_MIP      12'h344
`define RV32_IRQ_CODE_MTI 4'd7
`define RV32_IRQ_CODE_MEI 4'd11
`endif

package rv32_trap_ctrl_pkg;
  localparam logic [11:0] CSR_MSTATUS  = `RV32_CSR_MSTATUS;
  localparam logic [11:0] CSR_MIE      = `RV32_CSR_MIE;
  localparam logic [11:0] CSR_MTVEC    = `RV32_CSR_MTVEC;
  localparam logic [11:0] CSR_MSCRATCH = `RV32_CSR_MSCRATCH;
  localparam logic [11:0] CSR_MEPC     = `RV32_CSR_MEPC;
  localparam logic [11:0] CSR_MCAUSE   = `RV32_CSR_MCAUSE;
  localparam logic [11:0] CSR_MTVAL    = `RV32_CSR_MTVAL;
  localparam logic [11:0] CSR_MIP      = `RV32_CSR_MIP;

  localparam logic [3:0]  IRQ_CODE_MTI = `RV32_IRQ_CODE_MTI;
  localparam logic [3:0]  IRQ_CODE_MEI = `RV32_IRQ_CODE_MEI;
  localparam logic [31:0] MIE_WMASK    = 32'h0000_0880;

  // MODE values 2 and 3 are reserved and collapse to direct mode.
  function automatic logic [31:0] mtvec_legalize(input logic [31:0] v);
`ifdef RV32_TRAP_VECTORED_EN
    return {v[31:2], 1'b0, (v[1:0] == 2'b01)};
`else
    return {v[31:2], 2'b00};
`endif
  endfunction
endpackage

// File: rtl/rv32_trap_ctrl_if.sv
// Pipeline-facing bundle of the trap controller: exceptions, IRQs, MRET, CSR access and redirect.
interface rv32_trap_ctrl_if;
  logic        exc_valid_in;
  logic [3:0]  exc_cause_in;
  logic [31:0] exc_pc_in;
  logic [31:0] exc_tval_in;
  logic        mret_in;
  logic        boundary_in;
  logic [31:0] next_pc_in;
  logic        irq_timer_in;
  logic        irq_ext_in;
  logic        csr_read_in;
  logic        csr_write_in;
  logic [11:0] csr_in;
  logic [31:0] csr_write_value_in;
  logic [31:0] csr_read_value_out;
  logic        csr_hit_out;
  logic        busy_out;
  logic        redirect_valid_out;
  logic [31:0] redirect_pc_out;

  modport master (
    output exc_valid_in, exc_cause_in, exc_pc_in, exc_tval_in, mret_in, boundary_in,
           next_pc_in, irq_timer_in, irq_ext_in, csr_read_in, csr_write_in, csr_in,
           csr_write_value_in,
    input  csr_read_value_out, csr_hit_out, busy_out, redirect_valid_out, redirect_pc_out
  );

  modport slave (
    input  exc_valid_in, exc_cause_in, exc_pc_in, exc_tval_in, mret_in, boundary_in,
           next_pc_in, irq_timer_in, irq_ext_in, csr_read_in, csr_write_in, csr_in,
           csr_write_value_in,
    output csr_read_value_out, csr_hit_out, busy_out, redirect_valid_out, redirect_pc_out
  );
endinterface

// File: rtl/rv32_trap_irq_sel.sv
// Pending-interrupt priority select: external (11) wins over timer (7).
module rv32_trap_irq_sel
  import rv32_trap_ctrl_pkg::*;
(
  input  logic       enable,
  input  logic       pend_timer,
  input  logic       pend_ext,
  output logic       valid,
  output logic [3:0] code
);
  always_comb begin
    valid = enable & (pend_timer | pend_ext);
    code  = pend_ext ? IRQ_CODE_MEI : IRQ_CODE_MTI;
  end
endmodule

// File: rtl/rv32_trap_ctrl.sv
// Machine-mode trap CSRs plus trap-entry / MRET sequencer (IDLE -> TRAP|RETURN -> REDIRECT).
// RV32_TRAP_VECTORED_EN enables vectored interrupt targets through mtvec.MODE.
module rv32_trap_ctrl
  import rv32_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  rv32_trap_ctrl_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_TRAP, ST_RETURN, ST_REDIRECT} state_t;

  state_t      state, state_nxt;
  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, mtval_reg;
  logic [31:0] target, trap_target, mip_val, mtvec_base;
  logic        lat_irq;
  logic [3:0]  lat_code;
  logic [31:0] lat_pc, lat_tval;
  logic        irq_valid, accept;
  logic [3:0]  irq_code;

  assign mip_val    = {20'b0, bus.irq_ext_in, 3'b0, bus.irq_timer_in, 7'b0};
  assign mtvec_base = {mtvec_reg[31:2], 2'b00};

  rv32_trap_irq_sel u_irq_sel (
    .enable     (mstatus_mie & bus.boundary_in),
    .pend_timer (mie_reg[7] & mip_val[7]),
    .pend_ext   (mie_reg[11] & mip_val[11]),
    .valid      (irq_valid),
    .code       (irq_code)
  );

`ifdef RV32_TRAP_VECTORED_EN
  assign trap_target = (lat_irq && mtvec_reg[0]) ? mtvec_base + {26'b0, lat_code, 2'b00}
                                                 : mtvec_base;
`else
  assign trap_target = mtvec_base;
`endif

  always_comb begin
    state_nxt              = state;
    accept                 = 1'b0;
    bus.busy_out           = (state != ST_IDLE);
    bus.redirect_valid_out = 1'b0;
    bus.redirect_pc_out    = 32'h0;
    case (state)
      ST_IDLE: begin
        if (bus.exc_valid_in || irq_valid) begin
          state_nxt = ST_TRAP;
          accept    = 1'b1;
        end else if (bus.mret_in) begin
          state_nxt = ST_RETURN;
          accept    = 1'b1;
        end
      end
      ST_TRAP:   state_nxt = ST_REDIRECT;
      ST_RETURN: state_nxt = ST_REDIRECT;
      ST_REDIRECT: begin
        state_nxt              = ST_IDLE;
        bus.redirect_valid_out = 1'b1;
        bus.redirect_pc_out    = target;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_reg      <= 32'h0;
      mtvec_reg    <= mtvec_legalize(MTVEC_RESET);
      mscratch_reg <= 32'h0;
      mepc_reg     <= 32'h0;
      mcause_reg   <= 32'h0;
      mtval_reg    <= 32'h0;
      target       <= 32'h0;
      lat_irq      <= 1'b0;
      lat_code     <= 4'h0;
      lat_pc       <= 32'h0;
      lat_tval     <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (bus.exc_valid_in) begin
            lat_irq  <= 1'b0;
            lat_code <= bus.exc_cause_in;
            lat_pc   <= bus.exc_pc_in;
            lat_tval <= bus.exc_tval_in;
          end else if (irq_valid) begin
            lat_irq  <= 1'b1;
            lat_code <= irq_code;
            lat_pc   <= bus.next_pc_in;
            lat_tval <= 32'h0;
          end
          // A CSR write racing an accepted event is dropped.
          if (bus.csr_write_in && !accept) begin
            case (bus.csr_in)
              CSR_MSTATUS: begin
                mstatus_mie  <= bus.csr_write_value_in[3];
                mstatus_mpie <= bus.csr_write_value_in[7];
              end
              CSR_MIE:      mie_reg      <= bus.csr_write_value_in & MIE_WMASK;
              CSR_MTVEC:    mtvec_reg    <= mtvec_legalize(bus.csr_write_value_in);
              CSR_MSCRATCH: mscratch_reg <= bus.csr_write_value_in;
              CSR_MEPC:     mepc_reg     <= {bus.csr_write_value_in[31:2], 2'b00};
              CSR_MCAUSE:   mcause_reg   <= bus.csr_write_value_in;
              CSR_MTVAL:    mtval_reg    <= bus.csr_write_value_in;
              default: ;
            endcase
          end
        end
        ST_TRAP: begin
          mepc_reg     <= lat_pc & ~32'h3;
          mcause_reg   <= {lat_irq, 27'b0, lat_code};
          mtval_reg    <= lat_tval;
          mstatus_mpie <= mstatus_mie;
          mstatus_mie  <= 1'b0;
          target       <= trap_target;
        end
        ST_RETURN: begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
          target       <= mepc_reg;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.csr_hit_out        = 1'b1;
    bus.csr_read_value_out = 32'h0;
    case (bus.csr_in)
      CSR_MSTATUS:  bus.csr_read_value_out = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0,
                                              mstatus_mie, 3'b0};
      CSR_MIE:      bus.csr_read_value_out = mie_reg;
      CSR_MTVEC:    bus.csr_read_value_out = mtvec_reg;
      CSR_MSCRATCH: bus.csr_read_value_out = mscratch_reg;
      CSR_MEPC:     bus.csr_read_value_out = mepc_reg;
      CSR_MCAUSE:   bus.csr_read_value_out = mcause_reg;
      CSR_MTVAL:    bus.csr_read_value_out = mtval_reg;
      CSR_MIP:      bus.csr_read_value_out = mip_val;
      default:      bus.csr_hit_out        = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_rv32_trap_ctrl.sv
// Scoreboarded bench for rv32_trap_ctrl: expected redirects queued at stimulus, checked on the pulse.
module tb_rv32_trap_ctrl;
  import rv32_trap_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  rv32_trap_ctrl_if tif ();

  rv32_trap_ctrl #(.MTVEC_RESET(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tif.redirect_valid_out === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL redirect_unexpected pc=%h cyc=%0d", tif.redirect_pc_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (tif.redirect_pc_out !== e.pc || cyc != e.cyc) begin
          n_err++;
          $display("FAIL redirect pc=%h cyc=%0d expected pc=%h cyc=%0d",
                   tif.redirect_pc_out, cyc, e.pc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called when an event is driven; it is sampled at the next edge and redirects one cycle later.
  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] v);
    tif.csr_write_in       = 1'b1;
    tif.csr_in             = a;
    tif.csr_write_value_in = v;
    tick();
    tif.csr_write_in       = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] v, output logic h);
    tif.csr_read_in = 1'b1;
    tif.csr_in      = a;
    #1;
    v = tif.csr_read_value_out;
    h = tif.csr_hit_out;
    tif.csr_read_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (tif.busy_out !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    n_vec++;
    if (tif.busy_out !== 1'b0) begin n_err++; $display("FAIL %s_idle_timeout busy=%b expected 0", tag, tif.busy_out); end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic h;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_vec++; if (tif.busy_out !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", tif.busy_out); end
    n_vec++; if (tif.redirect_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got=%b exp=0", tif.redirect_valid_out); end
    n_vec++; if (tif.redirect_pc_out !== 32'h0) begin n_err++; $display("FAIL rst_rpc got=%h exp=0", tif.redirect_pc_out); end
    csr_rd(CSR_MSTATUS, v, h);
    n_vec++; if (v !== 32'h1800 || h !== 1'b1) begin n_err++; $display("FAIL rst_mstatus got=%h hit=%b exp=00001800 hit=1", v, h); end
    csr_rd(CSR_MTVEC, v, h);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_mtvec got=%h exp=0", v); end
    csr_rd(CSR_MEPC, v, h);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_mepc got=%h exp=0", v); end
    csr_rd(12'hC00, v, h);
    n_vec++; if (v !== 32'h0 || h !== 1'b0) begin n_err++; $display("FAIL miss_addr got=%h hit=%b exp=0 hit=0", v, h); end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    logic h;
    csr_wr(CSR_MTVEC, 32'h80);
    tif.exc_valid_in = 1'b1; tif.exc_cause_in = 4'd2;
    tif.exc_pc_in = 32'h100; tif.exc_tval_in = 32'hDEAD;
    push(32'h80);
    tick();
    tif.exc_valid_in = 1'b0;
    n_vec++; if (tif.busy_out !== 1'b1) begin n_err++; $display("FAIL exc_busy got=%b exp=1", tif.busy_out); end
    wait_idle("exc");
    csr_rd(CSR_MEPC, v, h);
    n_vec++; if (v !== 32'h100) begin n_err++; $display("FAIL exc_mepc got=%h exp=00000100", v); end
    csr_rd(CSR_MCAUSE, v, h);
    n_vec++; if (v !== 32'h2) begin n_err++; $display("FAIL exc_mcause got=%h exp=00000002", v); end
    csr_rd(CSR_MTVAL, v, h);
    n_vec++; if (v !== 32'hDEAD) begin n_err++; $display("FAIL exc_mtval got=%h exp=0000dead", v); end
    csr_rd(CSR_MSTATUS, v, h);
    n_vec++; if (v !== 32'h1800) begin n_err++; $display("FAIL exc_mstatus got=%h exp=00001800", v); end
    csr_wr(CSR_MEPC, 32'h123);
    csr_rd(CSR_MEPC, v, h);
    n_vec++; if (v !== 32'h120) begin n_err++; $display("FAIL mepc_align got=%h exp=00000120", v); end
  endtask

  task automatic test_irq_priority();
    logic [31:0] v;
    logic h;
    csr_wr(CSR_MSTATUS, 32'h8);
    csr_wr(CSR_MIE, 32'hFFFF_FFFF);
    csr_rd(CSR_MIE, v, h);
    n_vec++; if (v !== 32'h880) begin n_err++; $display("FAIL mie_mask got=%h exp=00000880", v); end
    tif.irq_timer_in = 1'b1; tif.irq_ext_in = 1'b1;
    csr_rd(CSR_MIP, v, h);
    n_vec++; if (v !== 32'h880) begin n_err++; $display("FAIL mip got=%h exp=00000880", v); end
    csr_wr(CSR_MIP, 32'h0);
    csr_rd(CSR_MIP, v, h);
    n_vec++; if (v !== 32'h880) begin n_err++; $display("FAIL mip_ro got=%h exp=00000880", v); end
    tif.boundary_in = 1'b1; tif.next_pc_in = 32'h204;
    push(32'h80);
    tick();
    tif.boundary_in = 1'b0;
    tick();
    tif.irq_timer_in = 1'b0; tif.irq_ext_in = 1'b0;
    wait_idle("irq");
    csr_rd(CSR_MCAUSE, v, h);
    n_vec++; if (v !== 32'h8000_000B) begin n_err++; $display("FAIL irq_mcause got=%h exp=8000000b", v); end
    csr_rd(CSR_MEPC, v, h);
    n_vec++; if (v !== 32'h204) begin n_err++; $display("FAIL irq_mepc got=%h exp=00000204", v); end
    csr_rd(CSR_MTVAL, v, h);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL irq_mtval got=%h exp=0", v); end
    csr_rd(CSR_MSTATUS, v, h);
    n_vec++; if (v !== 32'h1880) begin n_err++; $display("FAIL irq_mstatus got=%h exp=00001880", v); end
  endtask

  task automatic test_mret();
    logic [31:0] v;
    logic h;
    tif.mret_in = 1'b1;
    push(32'h204);
    tick();
    tif.mret_in = 1'b0;
    wait_idle("mret");
    csr_rd(CSR_MSTATUS, v, h);
    n_vec++; if (v !== 32'h1888) begin n_err++; $display("FAIL mret_mstatus got=%h exp=00001888", v); end
  endtask

  task automatic test_write_drop();
    logic [31:0] v;
    logic h;
    csr_wr(CSR_MSCRATCH, 32'h11);
    csr_rd(CSR_MSCRATCH, v, h);
    n_vec++; if (v !== 32'h11) begin n_err++; $display("FAIL mscratch_wr got=%h exp=00000011", v); end
    tif.exc_valid_in = 1'b1; tif.exc_cause_in = 4'd5;
    tif.exc_pc_in = 32'h300; tif.exc_tval_in = 32'h0;
    tif.csr_write_in = 1'b1; tif.csr_in = CSR_MSCRATCH; tif.csr_write_value_in = 32'h55;
    push(32'h80);
    tick();
    tif.exc_valid_in = 1'b0; tif.csr_write_in = 1'b0;
    wait_idle("drop");
    csr_rd(CSR_MSCRATCH, v, h);
    n_vec++; if (v !== 32'h11) begin n_err++; $display("FAIL drop_mscratch got=%h exp=00000011", v); end
    csr_rd(CSR_MCAUSE, v, h);
    n_vec++; if (v !== 32'h5) begin n_err++; $display("FAIL drop_mcause got=%h exp=00000005", v); end
  endtask

  task automatic test_vectored();
    logic [31:0] v, exp_pc;
    logic h;
    csr_wr(CSR_MSTATUS, 32'h8);
`ifdef RV32_TRAP_VECTORED_EN
    csr_wr(CSR_MTVEC, 32'h203);
    csr_rd(CSR_MTVEC, v, h);
    n_vec++; if (v !== 32'h200) begin n_err++; $display("FAIL mtvec_mode3 got=%h exp=00000200", v); end
    csr_wr(CSR_MTVEC, 32'h201);
    csr_rd(CSR_MTVEC, v, h);
    n_vec++; if (v !== 32'h201) begin n_err++; $display("FAIL mtvec_vec got=%h exp=00000201", v); end
    exp_pc = 32'h21C;
`else
    csr_wr(CSR_MTVEC, 32'h201);
    csr_rd(CSR_MTVEC, v, h);
    n_vec++; if (v !== 32'h200) begin n_err++; $display("FAIL mtvec_direct got=%h exp=00000200", v); end
    exp_pc = 32'h200;
`endif
    tif.irq_timer_in = 1'b1; tif.boundary_in = 1'b1; tif.next_pc_in = 32'h400;
    push(exp_pc);
    tick();
    tif.boundary_in = 1'b0; tif.irq_timer_in = 1'b0;
    wait_idle("vec");
    csr_rd(CSR_MCAUSE, v, h);
    n_vec++; if (v !== 32'h8000_0007) begin n_err++; $display("FAIL vec_mcause got=%h exp=80000007", v); end
  endtask

  task automatic test_reset_in_trap();
    logic [31:0] v;
    logic h;
    tif.exc_valid_in = 1'b1; tif.exc_cause_in = 4'd3;
    tif.exc_pc_in = 32'h500; tif.exc_tval_in = 32'h77;
    tick();
    tif.exc_valid_in = 1'b0;
    n_vec++; if (tif.busy_out !== 1'b1) begin n_err++; $display("FAIL rtrap_busy_pre got=%b exp=1", tif.busy_out); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (tif.busy_out !== 1'b0 || tif.redirect_valid_out !== 1'b0) begin n_err++; $display("FAIL rtrap_idle busy=%b rvalid=%b exp=0,0", tif.busy_out, tif.redirect_valid_out); end
    repeat (3) tick();
    csr_rd(CSR_MSTATUS, v, h);
    n_vec++; if (v !== 32'h1800) begin n_err++; $display("FAIL rtrap_mstatus got=%h exp=00001800", v); end
    csr_rd(CSR_MIE, v, h);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rtrap_mie got=%h exp=0", v); end
    csr_rd(CSR_MTVEC, v, h);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rtrap_mtvec got=%h exp=0", v); end
    csr_rd(CSR_MSCRATCH, v, h);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rtrap_mscratch got=%h exp=0", v); end
    csr_rd(CSR_MEPC, v, h);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rtrap_mepc got=%h exp=0", v); end
    csr_rd(CSR_MCAUSE, v, h);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rtrap_mcause got=%h exp=0", v); end
    csr_rd(CSR_MTVAL, v, h);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rtrap_mtval got=%h exp=0", v); end
  endtask

  initial begin
    tif.exc_valid_in = 1'b0; tif.exc_cause_in = 4'h0; tif.exc_pc_in = 32'h0; tif.exc_tval_in = 32'h0;
    tif.mret_in = 1'b0; tif.boundary_in = 1'b0; tif.next_pc_in = 32'h0;
    tif.irq_timer_in = 1'b0; tif.irq_ext_in = 1'b0;
    tif.csr_read_in = 1'b0; tif.csr_write_in = 1'b0; tif.csr_in = 12'h0; tif.csr_write_value_in = 32'h0;
    test_reset();
    test_exception();
    test_irq_priority();
    test_mret();
    test_write_drop();
    test_vectored();
    test_reset_in_trap();
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL redirect_missing pending=%0d expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
